ad_ip_jesd204_tpl_adc_rx_core: RTL and testbench
================================================

// Module: ad_ip_jesd204_tpl_adc_rx_core
// PURPOSE
// Receive-side JESD204 transport layer core, the mirror of the TPL DAC framer.
// - Deframes link-layer lane octets into per-converter samples.
// - Applies data-format conversion to the samples.
// - Presents the result to the DMA interface.
// - Runs a per-channel ramp pattern monitor for link bring-up.
// Sits between the JESD204 RX link layer and the ADC regmap / DMA on link_clk.
// PARAMETERS
// NUM_LANES            4   lanes (L)
// NUM_CHANNELS         2   converters (M)
// OCTETS_PER_BEAT      4   octets per lane per link_clk beat
// BITS_PER_SAMPLE      16  NP; only 16 supported
// CONVERTER_RESOLUTION 16  N, 8..16; sample MSB is bit N-1
// DATA_PATH_WIDTH      OCTETS_PER_BEAT*8*NUM_LANES/NUM_CHANNELS/16  samples/channel/beat (localparam)
// PN_LOCK_COUNT        4   consecutive good/bad beats to enter/leave lock
// PORTS
// link_clk         in   1          core clock (line-rate/40)
// reset            in   1          synchronous, active-high
// link_valid       in   1          link_data qualifier
// link_ready       out  1          always 1 except during reset
// link_data        in   L*8*OPB    lane l at [l*8*OPB +: 8*OPB]; octet 0 (LSB) earliest
// enable           in   M          per-channel enable from regmap
// adc_valid        out  M          per-channel sample qualifier
// adc_data         out  M*DPW*16   channel c at [c*DPW*16 +: DPW*16]; sample 0 (LSB) earliest
// adc_dfmt_enable  in   1          1 = apply format conversion
// adc_dfmt_type    in   1          1 = input is offset binary (invert bit N-1)
// adc_dfmt_se      in   1          1 = sign-extend bit N-1 to bit 15; 0 = zero-fill
// adc_pn_oos       out  M          1 = ramp monitor out of sync
// adc_pn_err       out  M          1-cycle pulse per mismatching beat while locked
// BEHAVIOUR
// Reset values:
// - link_ready=0, adc_valid=0, adc_data=0, adc_pn_err=0, adc_pn_oos=all 1.
// - Monitor counters and the expected-value register clear to 0.
// Deframing (S=1, F=2*M/L; F must divide OPB):
// - Frame octets are serialised lane 0 first, then lane 1, and so on.
// - Within each lane, octets are taken in time order.
// - Converter m takes octets 2m (MSB) and 2m+1 (LSB) of the serialised frame.
// - Frame k of the beat (k = 0..DPW-1) yields sample k of each channel.
// Pipeline, fixed 2-cycle latency with no backpressure:
// - S1: register link_data/link_valid.
// - S2: unpack, format and register adc_data.
// - adc_valid[c] = link_valid delayed 2 cycles AND enable[c] (enable sampled at S2).
// - adc_data updates only when the S1 valid is 1; otherwise it holds.
// Format, per 16-bit sample x, N = CONVERTER_RESOLUTION:
// - If dfmt_enable & dfmt_type, bit N-1 is inverted.
// - Bits 15..N are then filled with bit N-1 if dfmt_enable & dfmt_se, else 0.
// - If dfmt_enable = 0, x passes unchanged.
// - When N = 16, only the inversion applies.
// Ramp monitor, per channel, on formatted data, valid beats only:
// - A beat is good iff s[k+1] = s[k]+1 mod 2^N for all k, and s[0] = expected.
// - Sample compare uses the low N bits.
// - expected = last sample of the previous valid beat + 1, wrapping 2^N-1 -> 0.
// - OOS state: count consecutive beats that are internally consistent (s[0] check ignored).
//   Reaching PN_LOCK_COUNT -> LOCKED and clear the counter.
//   An inconsistent beat clears the counter.
// - LOCKED state: a bad beat pulses adc_pn_err and increments the counter.
//   PN_LOCK_COUNT consecutive bad beats -> OOS.
//   A good beat clears the counter.
// - Invalid beats freeze the state, counter and expected value.
// - enable[c]=0 forces that channel to OOS with counter 0.
// - Outputs are registered and aligned to the adc_valid beat they describe.
// - Reset mid-stream returns everything to reset values on the next edge.
// - The first valid beat after reset arrives at the output 2 cycles later.
// TESTING
// 1. L=4 M=2, ramp 0,1,2,... on both channels, link_valid=1:
//    - adc_valid=2'b11 from cycle 3.
//    - ch0 beat 0 = {16'h0003,16'h0002,16'h0001,16'h0000}.
//    - adc_pn_oos drops to 0 after 4 valid beats.
// 2. Locked; corrupt one ch1 sample to 16'hDEAD for one beat:
//    - adc_pn_err[1] pulses once; adc_pn_oos stays 0.
//    - The next good beat clears the counter.
// 3. Locked; 4 consecutive corrupted ch0 beats -> adc_pn_oos[0]=1 after the 4th; ch1 unaffected.
// 4. N=12, dfmt_enable=1, type=1, se=1; input 12'h000 -> 16'hF800; 12'hFFF -> 16'h07FF.
//    With dfmt_enable=0, 16'h0ABC passes unchanged.
// 5. Toggle link_valid 1-0-1 during a ramp:
//    - adc_valid follows with 2-cycle delay; adc_data holds on gaps.
//    - The ramp remains locked across the gap.
// 6. Assert reset mid-stream:
//    - All outputs are at reset values on the next cycle; adc_pn_oos=all 1.
//    - Ramp wrap 16'hFFFF -> 16'h0000 after reset raises no error.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_rx_core.sv
// ad_ip_jesd204_tpl_adc_rx_core
//
// Receive-side JESD204 transport layer. It deframes lane octets into
// per-converter samples and applies optional data-format conversion. The
// result goes to the DMA side. A per-channel ramp monitor is provided for
// link bring-up.
//
// Ports
//   link_clk          core clock
//   reset             synchronous, active-high
//   link_valid        qualifies link_data
//   link_ready        1 whenever not in reset (registered)
//   link_data         lane l at [l*8*OPB +: 8*OPB], octet 0 (LSB) earliest
//   enable            per-channel enable
//   adc_valid         per-channel sample qualifier
//   adc_data          channel c at [c*DPW*16 +: DPW*16], sample 0 (LSB) earliest
//   adc_dfmt_enable   apply format conversion
//   adc_dfmt_type     input is offset binary (invert bit N-1)
//   adc_dfmt_se       sign-extend bit N-1 (else zero-fill)
//   adc_pn_oos        ramp monitor out of sync
//   adc_pn_err        one-cycle pulse per bad beat while locked
module ad_ip_jesd204_tpl_adc_rx_core #(
  parameter int NUM_LANES            = 4,
  parameter int NUM_CHANNELS         = 2,
  parameter int OCTETS_PER_BEAT      = 4,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int PN_LOCK_COUNT        = 4
) (
  input  logic                                   link_clk,
  input  logic                                   reset,
  input  logic                                   link_valid,
  output logic                                   link_ready,
  input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] link_data,
  input  logic [NUM_CHANNELS-1:0]                enable,
  output logic [NUM_CHANNELS-1:0]                adc_valid,
  output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] adc_data,
  input  logic                                   adc_dfmt_enable,
  input  logic                                   adc_dfmt_type,
  input  logic                                   adc_dfmt_se,
  output logic [NUM_CHANNELS-1:0]                adc_pn_oos,
  output logic [NUM_CHANNELS-1:0]                adc_pn_err
);

  localparam int LANE_BITS        = 8 * OCTETS_PER_BEAT;
  localparam int DATA_BITS        = NUM_LANES * LANE_BITS;
  localparam int DATA_PATH_WIDTH  = DATA_BITS / NUM_CHANNELS / BITS_PER_SAMPLE;
  localparam int OCTETS_PER_FRAME = 2 * NUM_CHANNELS / NUM_LANES;
  localparam int RES              = CONVERTER_RESOLUTION;
  localparam int CNT_W            = $clog2(PN_LOCK_COUNT + 1);

  localparam logic [15:0]      MSB_MASK  = 16'h0001 << (RES - 1);
  localparam logic [15:0]      HIGH_MASK = 16'hFFFF << RES;   // bits 15..N
  localparam logic [RES-1:0]   RES_ONE   = RES'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PN_LOCK_COUNT - 1);

  // ---------------- S1: input register ----------------
  logic                 link_valid_reg;
  logic [DATA_BITS-1:0] link_data_reg;

  always_ff @(posedge link_clk) begin
    if (reset) begin
      link_valid_reg <= 1'b0;
      link_data_reg  <= '0;
      link_ready     <= 1'b0;
    end else begin
      link_valid_reg <= link_valid;
      link_data_reg  <= link_data;
      link_ready     <= 1'b1;
    end
  end

  // ---------------- unpack + format (combinational into S2) ----------------
  logic                 invert;
  logic                 fill;
  logic [DATA_BITS-1:0] adc_data_next;

  assign invert = adc_dfmt_enable & adc_dfmt_type;
  assign fill   = adc_dfmt_enable & adc_dfmt_se;

  for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_chan
    for (genvar gk = 0; gk < DATA_PATH_WIDTH; gk++) begin : g_samp
      // Serialised frame octet j lives in lane j/F at in-lane octet k*F + j%F.
      localparam int J_MSB   = 2 * gc;
      localparam int J_LSB   = 2 * gc + 1;
      localparam int POS_MSB = (J_MSB / OCTETS_PER_FRAME) * LANE_BITS
                             + (gk * OCTETS_PER_FRAME + J_MSB % OCTETS_PER_FRAME) * 8;
      localparam int POS_LSB = (J_LSB / OCTETS_PER_FRAME) * LANE_BITS
                             + (gk * OCTETS_PER_FRAME + J_LSB % OCTETS_PER_FRAME) * 8;

      logic [15:0] raw;
      logic [15:0] flipped;
      logic [15:0] ext;

      assign raw     = {link_data_reg[POS_MSB +: 8], link_data_reg[POS_LSB +: 8]};
      assign flipped = raw ^ (MSB_MASK & {16{invert}});
      assign ext     = {16{flipped[RES-1] & fill}};
      // HIGH_MASK is empty at N = 16, leaving only the inversion.
      assign adc_data_next[(gc*DATA_PATH_WIDTH + gk)*16 +: 16] =
        adc_dfmt_enable ? ((flipped & ~HIGH_MASK) | (ext & HIGH_MASK)) : raw;
    end
  end

  // ---------------- S2: output register ----------------
  always_ff @(posedge link_clk) begin
    if (reset) begin
      adc_valid <= '0;
      adc_data  <= '0;
    end else begin
      adc_valid <= {NUM_CHANNELS{link_valid_reg}} & enable;
      if (link_valid_reg)
        adc_data <= adc_data_next;
    end
  end

  // ---------------- ramp monitor, registered alongside S2 ----------------
  for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_mon
    localparam int BASE = gc * DATA_PATH_WIDTH * 16;

    logic             consistent;
    logic [RES-1:0]   first;
    logic [RES-1:0]   last;
    logic             oos_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [RES-1:0]   expected_reg;

    assign first = adc_data_next[BASE +: RES];
    assign last  = adc_data_next[BASE + (DATA_PATH_WIDTH-1)*16 +: RES];

    // Compare is N bits wide so the increment wraps at 2^N.
    always_comb begin
      consistent = 1'b1;
      for (int k = 0; k < DATA_PATH_WIDTH - 1; k++) begin
        if (adc_data_next[BASE + (k+1)*16 +: RES] != adc_data_next[BASE + k*16 +: RES] + RES_ONE)
          consistent = 1'b0;
      end
    end

    always_ff @(posedge link_clk) begin
      if (reset) begin
        oos_reg      <= 1'b1;
        err_reg      <= 1'b0;
        cnt_reg      <= '0;
        expected_reg <= '0;
      end else begin
        err_reg <= 1'b0;
        if (link_valid_reg)
          expected_reg <= last + RES_ONE;
        if (!enable[gc]) begin
          oos_reg <= 1'b1;
          cnt_reg <= '0;
        end else if (link_valid_reg) begin
          if (oos_reg) begin
            // Searching: only in-beat consistency counts towards lock.
            if (!consistent) begin
              cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
              oos_reg <= 1'b0;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end else begin
            if (consistent && first == expected_reg) begin
              cnt_reg <= '0;
            end else begin
              err_reg <= 1'b1;
              if (cnt_reg == CNT_LAST) begin
                oos_reg <= 1'b1;
                cnt_reg <= '0;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end
          end
        end
      end
    end

    assign adc_pn_oos[gc] = oos_reg;
    assign adc_pn_err[gc] = err_reg;
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_rx_core.sv
// Directed testbench for ad_ip_jesd204_tpl_adc_rx_core (L=4, M=2, OPB=4).
// A second instance with N=12 covers the narrow-resolution format paths.
module tb_ad_ip_jesd204_tpl_adc_rx_core;

  logic link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  logic         reset;
  logic         link_valid;
  logic [127:0] link_data;
  logic [1:0]   enable;
  logic         dfmt_enable, dfmt_type, dfmt_se;
  logic         link_ready;
  logic [1:0]   adc_valid;
  logic [127:0] adc_data;
  logic [1:0]   adc_pn_oos, adc_pn_err;

  logic         n12_dfmt_enable, n12_dfmt_type, n12_dfmt_se;
  logic         n12_link_ready;
  logic [1:0]   n12_adc_valid;
  logic [127:0] n12_adc_data;
  logic [1:0]   n12_pn_oos, n12_pn_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] r0, r1;   // next ramp start per channel

  ad_ip_jesd204_tpl_adc_rx_core dut (
    .link_clk(link_clk), .reset(reset), .link_valid(link_valid), .link_ready(link_ready),
    .link_data(link_data), .enable(enable), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_dfmt_enable(dfmt_enable), .adc_dfmt_type(dfmt_type), .adc_dfmt_se(dfmt_se),
    .adc_pn_oos(adc_pn_oos), .adc_pn_err(adc_pn_err)
  );

  ad_ip_jesd204_tpl_adc_rx_core #(.CONVERTER_RESOLUTION(12)) dut_n12 (
    .link_clk(link_clk), .reset(reset), .link_valid(link_valid), .link_ready(n12_link_ready),
    .link_data(link_data), .enable(enable), .adc_valid(n12_adc_valid), .adc_data(n12_adc_data),
    .adc_dfmt_enable(n12_dfmt_enable), .adc_dfmt_type(n12_dfmt_type), .adc_dfmt_se(n12_dfmt_se),
    .adc_pn_oos(n12_pn_oos), .adc_pn_err(n12_pn_err)
  );

  // Four consecutive ramp samples, sample 0 in the LSBs.
  function automatic logic [63:0] ramp64(input logic [15:0] s);
    logic [15:0] a1, a2, a3;
    a1 = s + 16'd1;
    a2 = s + 16'd2;
    a3 = s + 16'd3;
    return {a3, a2, a1, s};
  endfunction

  // Frame k: lane0/lane1 octet k carry ch0 MSB/LSB, lane2/lane3 carry ch1.
  function automatic logic [127:0] pack(input logic [63:0] c0, input logic [63:0] c1);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      d[0*32 + k*8 +: 8] = c0[k*16 + 8 +: 8];
      d[1*32 + k*8 +: 8] = c0[k*16 +: 8];
      d[2*32 + k*8 +: 8] = c1[k*16 + 8 +: 8];
      d[3*32 + k*8 +: 8] = c1[k*16 +: 8];
    end
    return d;
  endfunction

  // Present one beat, then wait to the next negedge. Outputs seen on return
  // describe the beat presented by the previous call.
  task automatic drive_beat(input logic v, input logic [63:0] c0, input logic [63:0] c1);
    link_valid = v;
    link_data  = pack(c0, c1);
    @(negedge link_clk);
    $display("[%0t] beat v=%0b ch0=%h ch1=%h | out v=%b oos=%b err=%b data=%h",
             $time, v, c0, c1, adc_valid, adc_pn_oos, adc_pn_err, adc_data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge link_clk);
    checks++; if (link_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", link_ready); end
    checks++; if (adc_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", adc_valid); end
    checks++; if (adc_data !== 128'h0) begin errors++; $display("FAIL reset_data: got %h want 0", adc_data); end
    checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", adc_pn_err); end
    checks++; if (adc_pn_oos !== 2'b11) begin errors++; $display("FAIL reset_oos: got %b want 11", adc_pn_oos); end
    reset = 1'b0;
    @(negedge link_clk);
    checks++; if (link_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", link_ready); end
    checks++; if (adc_pn_oos !== 2'b11) begin errors++; $display("FAIL release_oos: got %b want 11", adc_pn_oos); end
  endtask

  task automatic test_ramp();
    logic [63:0] b0, b1, p0, p1;
    int j;
    r0 = 16'h0000; r1 = 16'h0000;
    p0 = '0; p1 = '0;
    for (int i = 0; i <= 6; i++) begin
      b0 = ramp64(r0); b1 = ramp64(r1);
      drive_beat(i < 6, b0, b1);
      if (i < 6) begin r0 = r0 + 16'd4; r1 = r1 + 16'd4; end
      if (i == 0) begin
        checks++; if (adc_valid !== 2'b00) begin errors++; $display("FAIL ramp_first_valid: got %b want 00", adc_valid); end
      end else begin
        j = i - 1;
        checks++; if (adc_valid !== 2'b11) begin errors++; $display("FAIL ramp_valid beat %0d: got %b want 11", j, adc_valid); end
        checks++; if (adc_data !== {p1, p0}) begin errors++; $display("FAIL ramp_data beat %0d: got %h want %h", j, adc_data, {p1, p0}); end
        checks++; if (adc_pn_oos !== ((j >= 3) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL ramp_oos beat %0d: got %b want %b", j, adc_pn_oos, (j >= 3) ? 2'b00 : 2'b11); end
        checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL ramp_err beat %0d: got %b want 00", j, adc_pn_err); end
        if (j == 0) begin
          checks++; if (adc_data[63:0] !== 64'h0003_0002_0001_0000) begin errors++; $display("FAIL ramp_beat0_ch0: got %h want 0003000200010000", adc_data[63:0]); end
        end
      end
      p0 = b0; p1 = b1;
    end
  endtask

  // ch1 bad on beats 0,2,3,4; beat 1 must have cleared the bad-beat count.
  task automatic test_single_err();
    logic [63:0] b0, b1;
    logic [5:0]  bad;
    int j;
    bad = 6'b011101;
    for (int i = 0; i <= 6; i++) begin
      b0 = ramp64(r0); b1 = ramp64(r1);
      if (i < 6 && bad[i]) b1[31:16] = 16'hDEAD;
      drive_beat(i < 6, b0, b1);
      if (i < 6) begin r0 = r0 + 16'd4; r1 = r1 + 16'd4; end
      if (i > 0) begin
        j = i - 1;
        checks++; if (adc_pn_err !== (bad[j] ? 2'b10 : 2'b00)) begin errors++; $display("FAIL single_err beat %0d: got %b want %b", j, adc_pn_err, bad[j] ? 2'b10 : 2'b00); end
        checks++; if (adc_pn_oos !== 2'b00) begin errors++; $display("FAIL single_oos beat %0d: got %b want 00", j, adc_pn_oos); end
      end
    end
  endtask

  task automatic test_multi_err();
    logic [63:0] b0, b1;
    int j;
    for (int i = 0; i <= 8; i++) begin
      b0 = ramp64(r0); b1 = ramp64(r1);
      if (i < 4) b0[31:16] = 16'hDEAD;
      drive_beat(i < 8, b0, b1);
      if (i < 8) begin r0 = r0 + 16'd4; r1 = r1 + 16'd4; end
      if (i > 0) begin
        j = i - 1;
        checks++; if (adc_pn_err !== ((j < 4) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL multi_err beat %0d: got %b want %b", j, adc_pn_err, (j < 4) ? 2'b01 : 2'b00); end
        checks++; if (adc_pn_oos !== ((j >= 3 && j < 7) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL multi_oos beat %0d: got %b want %b", j, adc_pn_oos, (j >= 3 && j < 7) ? 2'b01 : 2'b00); end
      end
    end
  endtask

  task automatic test_valid_gap();
    logic [63:0] a0, a1, b0, b1;
    a0 = ramp64(r0); a1 = ramp64(r1);
    drive_beat(1'b1, a0, a1);
    r0 = r0 + 16'd4; r1 = r1 + 16'd4;
    drive_beat(1'b0, {4{16'h5A5A}}, {4{16'hA5A5}});
    checks++; if (adc_valid !== 2'b11) begin errors++; $display("FAIL gap_a_valid: got %b want 11", adc_valid); end
    checks++; if (adc_data !== {a1, a0}) begin errors++; $display("FAIL gap_a_data: got %h want %h", adc_data, {a1, a0}); end
    b0 = ramp64(r0); b1 = ramp64(r1);
    drive_beat(1'b1, b0, b1);
    r0 = r0 + 16'd4; r1 = r1 + 16'd4;
    checks++; if (adc_valid !== 2'b00) begin errors++; $display("FAIL gap_hole_valid: got %b want 00", adc_valid); end
    checks++; if (adc_data !== {a1, a0}) begin errors++; $display("FAIL gap_hold_data: got %h want %h", adc_data, {a1, a0}); end
    drive_beat(1'b0, {4{16'h5A5A}}, {4{16'hA5A5}});
    checks++; if (adc_valid !== 2'b11) begin errors++; $display("FAIL gap_b_valid: got %b want 11", adc_valid); end
    checks++; if (adc_data !== {b1, b0}) begin errors++; $display("FAIL gap_b_data: got %h want %h", adc_data, {b1, b0}); end
    checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL gap_b_err: got %b want 00", adc_pn_err); end
    checks++; if (adc_pn_oos !== 2'b00) begin errors++; $display("FAIL gap_b_oos: got %b want 00", adc_pn_oos); end
  endtask

  task automatic test_enable();
    enable = 2'b01;
    drive_beat(1'b1, ramp64(r0), ramp64(r1));
    r0 = r0 + 16'd4; r1 = r1 + 16'd4;
    checks++; if (adc_pn_oos !== 2'b10) begin errors++; $display("FAIL en_force_oos: got %b want 10", adc_pn_oos); end
    drive_beat(1'b0, '0, '0);
    checks++; if (adc_valid !== 2'b01) begin errors++; $display("FAIL en_valid_mask: got %b want 01", adc_valid); end
    enable = 2'b11;
    for (int i = 0; i <= 4; i++) begin
      drive_beat(i < 4, ramp64(r0), ramp64(r1));
      if (i < 4) begin r0 = r0 + 16'd4; r1 = r1 + 16'd4; end
      if (i > 0) begin
        checks++; if (adc_pn_oos !== ((i == 4) ? 2'b00 : 2'b10)) begin errors++; $display("FAIL en_relock beat %0d: got %b want %b", i - 1, adc_pn_oos, (i == 4) ? 2'b00 : 2'b10); end
        checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL en_err beat %0d: got %b want 00", i - 1, adc_pn_err); end
      end
    end
  endtask

  task automatic test_format();
    logic [2:0]  cfg [4];
    logic [63:0] in0 [4];
    logic [63:0] in1 [4];
    logic [63:0] ex0 [4];
    logic [63:0] ex1 [4];
    cfg = '{3'b111, 3'b100, 3'b101, 3'b011};   // {enable, type, se}
    in0 = '{64'h0123_0800_0FFF_0000, 64'hFABC_0ABC_F000_1FFF, 64'h0ABC_0800_07FF_F123, 64'hFABC_0ABC_1234_DEAD};
    ex0 = '{64'hF923_0000_07FF_F800, 64'h0ABC_0ABC_0000_0FFF, 64'hFABC_F800_07FF_0123, 64'hFABC_0ABC_1234_DEAD};
    in1 = '{64'h07FF_0001_0FFE_0400, 64'hFABC_0ABC_F000_1FFF, 64'h0ABC_0800_07FF_F123, 64'h0ABC_0ABC_0ABC_0ABC};
    ex1 = '{64'hFFFF_F801_07FE_FC00, 64'h0ABC_0ABC_0000_0FFF, 64'hFABC_F800_07FF_0123, 64'h0ABC_0ABC_0ABC_0ABC};
    for (int v = 0; v < 4; v++) begin
      {n12_dfmt_enable, n12_dfmt_type, n12_dfmt_se} = cfg[v];
      {dfmt_enable, dfmt_type, dfmt_se} = (v == 0) ? 3'b111 : 3'b000;
      drive_beat(1'b1, in0[v], in1[v]);
      drive_beat(1'b0, in0[v], in1[v]);
      checks++; if (n12_adc_data[63:0] !== ex0[v]) begin errors++; $display("FAIL fmt12_ch0 vec %0d: got %h want %h", v, n12_adc_data[63:0], ex0[v]); end
      checks++; if (n12_adc_data[127:64] !== ex1[v]) begin errors++; $display("FAIL fmt12_ch1 vec %0d: got %h want %h", v, n12_adc_data[127:64], ex1[v]); end
      if (v == 0) begin
        checks++; if (adc_data !== 128'h87FF_8001_8FFE_8400_8123_8800_8FFF_8000) begin errors++; $display("FAIL fmt16_invert: got %h want 87ff80018ffe8400812388008fff8000", adc_data); end
      end else begin
        checks++; if (adc_data !== {in1[v], in0[v]}) begin errors++; $display("FAIL fmt16_pass vec %0d: got %h want %h", v, adc_data, {in1[v], in0[v]}); end
      end
    end
    {dfmt_enable, dfmt_type, dfmt_se} = 3'b000;
  endtask

  task automatic test_reset_wrap();
    logic [63:0] b0, b1, p0, p1;
    int j;
    drive_beat(1'b1, ramp64(16'h1000), ramp64(16'h2000));
    drive_beat(1'b1, ramp64(16'h1004), ramp64(16'h2004));
    checks++; if (adc_valid !== 2'b11) begin errors++; $display("FAIL midrst_pre_valid: got %b want 11", adc_valid); end
    reset = 1'b1;
    drive_beat(1'b1, ramp64(16'h1008), ramp64(16'h2008));
    checks++; if (link_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", link_ready); end
    checks++; if (adc_valid !== 2'b00) begin errors++; $display("FAIL midrst_valid: got %b want 00", adc_valid); end
    checks++; if (adc_data !== 128'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", adc_data); end
    checks++; if (adc_pn_oos !== 2'b11) begin errors++; $display("FAIL midrst_oos: got %b want 11", adc_pn_oos); end
    checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL midrst_err: got %b want 00", adc_pn_err); end
    reset = 1'b0;
    r0 = 16'hFFF2;   // wraps inside a beat
    r1 = 16'hFFF0;   // wraps across a beat boundary while locked
    p0 = '0; p1 = '0;
    for (int i = 0; i <= 6; i++) begin
      b0 = ramp64(r0); b1 = ramp64(r1);
      drive_beat(i < 6, b0, b1);
      if (i < 6) begin r0 = r0 + 16'd4; r1 = r1 + 16'd4; end
      if (i == 0) begin
        checks++; if (adc_valid !== 2'b00) begin errors++; $display("FAIL wrap_first_valid: got %b want 00", adc_valid); end
      end else begin
        j = i - 1;
        checks++; if (adc_data !== {p1, p0}) begin errors++; $display("FAIL wrap_data beat %0d: got %h want %h", j, adc_data, {p1, p0}); end
        checks++; if (adc_pn_oos !== ((j >= 3) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL wrap_oos beat %0d: got %b want %b", j, adc_pn_oos, (j >= 3) ? 2'b00 : 2'b11); end
        checks++; if (adc_pn_err !== 2'b00) begin errors++; $display("FAIL wrap_err beat %0d: got %b want 00", j, adc_pn_err); end
      end
      p0 = b0; p1 = b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    link_valid = 1'b0;
    link_data = '0;
    enable = 2'b11;
    {dfmt_enable, dfmt_type, dfmt_se} = 3'b000;
    {n12_dfmt_enable, n12_dfmt_type, n12_dfmt_se} = 3'b000;
    r0 = '0; r1 = '0;
    test_reset();
    test_ramp();
    test_single_err();
    test_multi_err();
    test_valid_gap();
    test_enable();
    test_format();
    test_reset_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit reached");
  end

endmodule
